// File: rtl/hash_pe_result_deserializer.sv
// Return-path deserializer: regroups single-beat hash PE results into issue-width
// vectors aligned to a window head, emitted in the order their first beat arrived.
module hash_pe_result_deserializer #(
    parameter int ISSUE_WIDTH = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TMO_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [TMO_WIDTH-1:0]              cfg_flush_timeout,
    input  logic                              input_valid,
    input  logic [ADDR_WIDTH-1:0]             input_addr,
    input  logic [DATA_WIDTH-1:0]             input_data,
    input  logic                              input_delim,
    output logic                              input_ready,
    output logic                              output_valid,
    output logic [ADDR_WIDTH-1:0]             output_head_addr,
    output logic [ISSUE_WIDTH-1:0]            output_mask_vec,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] output_data_vec,
    output logic                              output_delim,
    input  logic                              output_ready,
    output logic                              busy
);
    localparam int LOG2 = $clog2(ISSUE_WIDTH);
    localparam int VW   = ISSUE_WIDTH * DATA_WIDTH;

    logic                   c_valid_r;
    logic                   c_closed_r;
    logic                   c_delim_r;
    logic [ADDR_WIDTH-1:0]  c_head_r;
    logic [ISSUE_WIDTH-1:0] c_mask_r;
    logic [VW-1:0]          c_data_r;
    logic [TMO_WIDTH-1:0]   tmo_cnt_r;

    logic [ADDR_WIDTH-1:0]  beat_head_s;
    logic [LOG2-1:0]        beat_lane_s;
    logic [ISSUE_WIDTH-1:0] beat_bit_s;
    logic                   o_free_s;
    logic                   merge_s;
    logic                   conflict_s;
    logic                   accept_s;
    logic                   tmo_hit_s;

    logic [ISSUE_WIDTH-1:0] b_mask_s;
    logic [VW-1:0]          b_data_s;
    logic                   b_delim_s;
    logic                   b_close_s;

    logic                   o_load_s;
    logic                   o_from_beat_s;
    logic                   c_load_s;
    logic                   c_clear_s;
    logic                   tmo_close_s;

    assign beat_head_s = {input_addr[ADDR_WIDTH-1:LOG2], {LOG2{1'b0}}};
    assign beat_lane_s = input_addr[LOG2-1:0];
    assign beat_bit_s  = {{(ISSUE_WIDTH-1){1'b0}}, 1'b1} << beat_lane_s;
    assign o_free_s    = !output_valid || output_ready;
    assign merge_s     = input_valid && c_valid_r && !c_closed_r &&
                         (beat_head_s == c_head_r) && ((c_mask_r & beat_bit_s) == '0);
    assign conflict_s  = input_valid && c_valid_r && !merge_s;
    assign input_ready = !rst && (!c_valid_r || merge_s || (o_free_s && (c_closed_r || conflict_s)));
    assign accept_s    = input_valid && input_ready;
    assign tmo_hit_s   = (cfg_flush_timeout != '0) && c_valid_r && !c_closed_r &&
                         (tmo_cnt_r == cfg_flush_timeout);
    assign busy        = c_valid_r || output_valid;

    // Candidate collect contents once the presented beat is folded in (merge or fresh open).
    always_comb begin
        b_data_s  = '0;
        b_mask_s  = merge_s ? (c_mask_r | beat_bit_s) : beat_bit_s;
        b_delim_s = (merge_s && c_delim_r) || input_delim;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (beat_lane_s == LOG2'(i)) begin
                b_data_s[i*DATA_WIDTH +: DATA_WIDTH] = input_data;
            end else if (merge_s) begin
                b_data_s[i*DATA_WIDTH +: DATA_WIDTH] = c_data_r[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                b_data_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
        b_close_s = b_delim_s || (&b_mask_s);
    end

    // Move/load decisions; a closing beat bypasses straight to O so it leaves next cycle.
    always_comb begin
        o_load_s      = 1'b0;
        o_from_beat_s = 1'b0;
        c_load_s      = 1'b0;
        c_clear_s     = 1'b0;
        tmo_close_s   = 1'b0;
        if (accept_s) begin
            if (conflict_s) begin
                o_load_s = 1'b1;
                c_load_s = 1'b1;
            end else if (b_close_s && o_free_s) begin
                o_load_s      = 1'b1;
                o_from_beat_s = 1'b1;
                c_clear_s     = 1'b1;
            end else begin
                c_load_s = 1'b1;
            end
        end else if (c_valid_r && c_closed_r && o_free_s) begin
            o_load_s  = 1'b1;
            c_clear_s = 1'b1;
        end else if (tmo_hit_s) begin
            tmo_close_s = 1'b1;
        end else begin
            tmo_close_s = 1'b0;
        end
    end

    // Collect buffer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid_r  <= 1'b0;
            c_closed_r <= 1'b0;
            c_delim_r  <= 1'b0;
            c_head_r   <= '0;
            c_mask_r   <= '0;
            c_data_r   <= '0;
        end else if (c_load_s) begin
            c_valid_r  <= 1'b1;
            c_closed_r <= b_close_s;
            c_delim_r  <= b_delim_s;
            c_head_r   <= beat_head_s;
            c_mask_r   <= b_mask_s;
            c_data_r   <= b_data_s;
        end else if (c_clear_s) begin
            c_valid_r  <= 1'b0;
            c_closed_r <= 1'b0;
            c_delim_r  <= 1'b0;
            c_head_r   <= '0;
            c_mask_r   <= '0;
            c_data_r   <= '0;
        end else if (tmo_close_s) begin
            c_closed_r <= 1'b1;
        end
    end

    // Output slot: held while stalled, refilled in the same cycle it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_valid     <= 1'b0;
            output_head_addr <= '0;
            output_mask_vec  <= '0;
            output_data_vec  <= '0;
            output_delim     <= 1'b0;
        end else if (o_load_s) begin
            output_valid <= 1'b1;
            if (o_from_beat_s) begin
                output_head_addr <= beat_head_s;
                output_mask_vec  <= b_mask_s;
                output_data_vec  <= b_data_s;
                output_delim     <= b_delim_s;
            end else begin
                output_head_addr <= c_head_r;
                output_mask_vec  <= c_mask_r;
                output_data_vec  <= c_data_r;
                output_delim     <= c_delim_r;
            end
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

    // Idle counter; holds at the threshold once it has closed the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (accept_s || !c_valid_r) begin
            tmo_cnt_r <= '0;
        end else if (!c_closed_r && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: doc/hash_pe_result_deserializer.md
# hash_pe_result_deserializer

- Gathers the serial per-request results returned by the hash PEs and repacks them into issue-width vectors.
- Each output vector is aligned to a window head address and carries a lane mask.
- It is the return-path counterpart of the hash PE request serializer: requests leave as single beats, and their results come back here to be regrouped for the downstream match stage.
- Result order is preserved: vectors leave in the order their first beat arrived.

## Interface
Parameters:
- ISSUE_WIDTH, default 8: lanes per vector; power of two, at least 2. LOG2 = log2(ISSUE_WIDTH).
- ADDR_WIDTH, default 32: byte-address width.
- DATA_WIDTH, default 32: per-result payload width.
- TMO_WIDTH, default 8: width of the flush-timeout config.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous, active-high.
- cfg_flush_timeout, in, TMO_WIDTH: number of idle cycles before a partial vector is closed; 0 disables the timeout.
- input_valid, in, 1: result beat valid.
- input_addr, in, ADDR_WIDTH: address of the request this result belongs to.
- input_data, in, DATA_WIDTH: result payload.
- input_delim, in, 1: last result of the block.
- input_ready, out, 1: beat accepted when input_valid && input_ready.
- output_valid, out, 1: vector valid.
- output_head_addr, out, ADDR_WIDTH: window head; low LOG2 bits are always 0.
- output_mask_vec, out, ISSUE_WIDTH: bit i set = lane i holds a result.
- output_data_vec, out, ISSUE_WIDTH*DATA_WIDTH: lane i is at [i*DATA_WIDTH +: DATA_WIDTH].
- output_delim, out, 1: vector contains a delim beat.
- output_ready, in, 1: downstream accepts the vector.
- busy, out, 1: collect buffer or output register is occupied.

## Operation
Storage:
- Collect buffer C holds: valid, closed, head, mask, data[ISSUE_WIDTH], delim.
- Output register O is a single slot that drives the output ports directly.

Per-beat decode:
- Beat head = input_addr with the low LOG2 bits cleared.
- Beat lane = input_addr[LOG2-1:0].

Merge rule: a beat merges into C when all of the following hold:
- C is valid and not closed;
- beat head == C.head;
- C.mask[lane] == 0.

A merging beat writes its lane data, sets the mask bit, and ORs its delim into C.delim.

Conflicting beat: a valid beat that cannot merge (different head, duplicate lane, or C closed) forces C to move to O. The beat then opens a new C with only its own lane set.

Close rules (C.closed is set in the same cycle C is written, or by the timeout):
- C.delim = 1;
- C.mask is all ones;
- the idle timeout fires.

Move C -> O:
- Allowed when o_free = !output_valid || output_ready.
- Happens when C is closed, or a conflicting beat is presented.
- When a move happens, O is loaded with C's contents, and C is cleared or reloaded by the conflicting beat.

input_ready is combinational:
- 1 when C is empty;
- 1 when the beat merges;
- 1 when the beat conflicts and o_free;
- 1 when C is closed and o_free;
- 0 otherwise, and 0 while rst is asserted.

Idle timeout counter:
- Cleared on reset, on any accepted beat, and when C is empty.
- Otherwise increments while C is valid and not closed.
- When the count equals a nonzero cfg_flush_timeout, C.closed is set and the counter saturates.

busy = C.valid || output_valid.

## Timing
- Reset values: output_valid 0, output_head_addr 0, output_mask_vec 0, output_data_vec 0, output_delim 0, busy 0; C and the counter are cleared.
- Closing beat (delim or lane fill) accepted in cycle N: the vector is on the output in cycle N+1 if O is free.
- Conflicting beat accepted in cycle N with o_free: the old C is valid on the output in cycle N+1, and the new C holds the beat. There are no bubbles, so a sustained stream of one beat per cycle is supported while output_ready = 1.
- O is held stable while output_valid && !output_ready.
- O is refilled in the same cycle it is accepted, giving back-to-back vectors.
- Timeout and accepted beat in the same cycle: the beat wins, the counter clears, and no close occurs.
- Closed C with O blocked: input_ready stays 0 until output_ready is asserted.
- Reset asserted mid-operation: all contents are dropped immediately; no partial vector is emitted after reset is released.
- Address wrap: the head comparison is full-width, so an address wrapping to 0 is a new window.

## Test plan
- **Merge then delim:** output_ready=1; beats at addr 0x40..0x47 with data = addr, delim on 0x47. Required: one vector, head 0x40, mask 0xFF, data lane i = 0x40+i, delim 1, output_valid on the cycle after the 0x47 beat.
- **Window change:** beats 0x41, 0x43, then 0x49. Required: vector head 0x40, mask 0x0A is emitted; C holds head 0x48, mask 0x02; input_ready stays 1 throughout.
- **Duplicate lane:** beats 0x42, 0x42 (data 1 then 2). Required: first vector mask 0x04 with data 1; second vector opens with data 2.
- **Backpressure:** output_ready=0; fill O, close C with a delim beat, then present a conflicting beat. Required: input_ready=0 and O held stable; after output_ready=1, the vectors drain in order.
- **Timeout:** cfg_flush_timeout=3; single beat 0x10, then idle. Required: vector head 0x10, mask 0x01 closes after 3 idle cycles. With cfg=0, the vector never closes.
- **Reset mid-fill:** assert rst with C and O valid. Required: all outputs 0 and busy 0 immediately; no stale vector after release.
